synaptic_integrator: RTL and testbench

Reads the Q8.8 synaptic weight matrix trained by the Hebbian learning block and turns a spike snapshot into one synaptic input current per neuron, I[i] = Σ_{j≠i, spikes[j]=1} w[i][j]. It walks the weights serially through a one-cycle-latency read port, one multiply-free accumulate per cycle. Each neuron's current is emitted on a valid/ready stream to the neuron array. The block sits between the weight store and the neuron update logic, once per network timestep.

---
 rtl/synaptic_integrator_if.sv | 28 ++
 rtl/synaptic_integrator.sv | 158 +++++++++++++++
 tb/tb_synaptic_integrator.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/synaptic_integrator_if.sv
// Weight-store read port and per-neuron current stream of the synaptic integrator.
interface synaptic_integrator_if #(
  parameter int N  = 7,
  parameter int IW = $clog2(N)
);
  logic                 w_rd_en;
  logic [IW-1:0]        w_rd_row;
  logic [IW-1:0]        w_rd_col;
  logic signed [15:0]   w_rd_data;
  logic                 cur_valid;
  logic                 cur_ready;
  logic [IW-1:0]        cur_idx;
  logic signed [15:0]   cur_data;

  modport master (
    output w_rd_en, w_rd_row, w_rd_col,
    input  w_rd_data,
    output cur_valid, cur_idx, cur_data,
    input  cur_ready
  );

  modport slave (
    input  w_rd_en, w_rd_row, w_rd_col,
    output w_rd_data,
    input  cur_valid, cur_idx, cur_data,
    output cur_ready
  );
endinterface

// File: rtl/synaptic_integrator.sv
// Serial Q8.8 synaptic current integrator: I[i] = sum over spiking j != i of w[i][j].
// Optional SYN_INT_SKIP_EN visits only spiking off-diagonal columns instead of all N.
module synaptic_integrator #(
  parameter int N     = 7,
  parameter int IW    = $clog2(N),
  parameter int ACC_W = 16 + $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [N-1:0]          spikes,
  synaptic_integrator_if.master bus,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, EMIT} state_t;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32'sd32768);

  state_t                   state_q, state_d;
  logic [IW-1:0]            row_q, row_d;
  logic [IW-1:0]            col_q, col_d;
  logic [IW-1:0]            col_prev;
  logic                     rd_en, rd_q;
  logic                     latch_snap, clear_acc, last_accept, done_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  w_ext;
  logic [N-1:0]             snap;
  logic [N-1:0]             visit_mask, entry_mask;
  logic [IW:0]              next_hit, entry_hit;

  // Lowest set bit of mask at or above 'from'; MSB of the result flags a hit.
  function automatic logic [IW:0] first_from(input logic [N-1:0] mask, input logic [IW:0] from);
    logic          found;
    logic [IW-1:0] idx;
    logic [N-1:0]  m;
    found = 1'b0;
    idx   = '0;
    for (int unsigned c = 0; c < N; c++) begin
      m = mask >> c;
      if (!found && (c >= 32'(from)) && m[0]) begin
        found = 1'b1;
        idx   = IW'(c);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic signed [15:0] saturate(input logic signed [ACC_W-1:0] a);
    if (a > SAT_HI)      return 16'sh7FFF;
    else if (a < SAT_LO) return 16'sh8000;
    else                 return a[15:0];
  endfunction

`ifdef SYN_INT_SKIP_EN
  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    return N'(1) << i;
  endfunction

  logic [IW-1:0] next_row;
  // Entry search for the row about to start: row 0 from the live spikes at start, else row+1 from snap.
  assign next_row   = (state_q == IDLE) ? '0 : row_q + IW'(1);
  assign visit_mask = snap & ~onehot(row_q);
  assign entry_mask = ((state_q == IDLE) ? spikes : snap) & ~onehot(next_row);
`else
  assign visit_mask = '1;
  assign entry_mask = '1;
`endif

  assign next_hit  = first_from(visit_mask, {1'b0, col_q} + (IW+1)'(1));
  assign entry_hit = first_from(entry_mask, '0);
  assign w_ext     = {{(ACC_W-16){bus.w_rd_data[15]}}, bus.w_rd_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    rd_en         = 1'b0;
    latch_snap    = 1'b0;
    clear_acc     = 1'b0;
    last_accept   = 1'b0;
    bus.w_rd_row  = '0;
    bus.w_rd_col  = '0;
    bus.cur_valid = 1'b0;
    bus.cur_idx   = '0;
    bus.cur_data  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch_snap = 1'b1;
          clear_acc  = 1'b1;
          row_d      = '0;
          col_d      = entry_hit[IW-1:0];
          state_d    = entry_hit[IW] ? READ : DRAIN;
        end
      end
      READ: begin
        bus.w_rd_row = row_q;
        bus.w_rd_col = col_q;
        rd_en        = (col_q != row_q);
        if (next_hit[IW]) col_d   = next_hit[IW-1:0];
        else              state_d = DRAIN;
      end
      DRAIN: state_d = EMIT;
      EMIT: begin
        bus.cur_valid = 1'b1;
        bus.cur_idx   = row_q;
        bus.cur_data  = saturate(acc);
        if (bus.cur_ready) begin
          if (row_q == IW'(N-1)) begin
            state_d     = IDLE;
            last_accept = 1'b1;
          end else begin
            row_d     = row_q + IW'(1);
            col_d     = entry_hit[IW-1:0];
            clear_acc = 1'b1;
            state_d   = entry_hit[IW] ? READ : DRAIN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data lands one cycle after the strobe, so the column is delayed alongside it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q    <= '0;
      col_q    <= '0;
      col_prev <= '0;
      rd_q     <= 1'b0;
      acc      <= '0;
      snap     <= '0;
      done_q   <= 1'b0;
    end else begin
      row_q    <= row_d;
      col_q    <= col_d;
      col_prev <= col_q;
      rd_q     <= rd_en;
      done_q   <= last_accept;
      if (latch_snap) snap <= spikes;
      if (clear_acc)                  acc <= '0;
      else if (rd_q && snap[col_prev]) acc <= acc + w_ext;
    end
  end

  assign bus.w_rd_en = rd_en;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_synaptic_integrator.sv
// Self-checking bench for synaptic_integrator: per-cycle behavioural model plus literal pins.
module tb_synaptic_integrator;
  localparam int N  = 7;
  localparam int IW = $clog2(N);

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] spikes = '0;
  logic         busy, done;

  synaptic_integrator_if #(.N(N)) bus ();

  synaptic_integrator #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .spikes  (spikes),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Weight store with one-cycle read latency; garbage when not strobed.
  logic signed [15:0] w_mem [N][N];
  logic signed [15:0] rdata = 16'sh5A5A;
  always @(posedge clk) rdata <= bus.w_rd_en ? w_mem[bus.w_rd_row][bus.w_rd_col] : 16'sh5A5A;
  assign bus.w_rd_data = rdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural model state
  bit           active = 1'b0;
  int           t0 = 0, row_m = 0, due = 0, done_due = -1, last_col = -1, reads = 0;
  int           stall_r = -1, stall_n = 0;
  logic [N-1:0] snap_m = '0;
  logic [15:0]  got [N];
  int           emit_first [N];
  int           accept_cyc [N];
  logic         exp_valid;

  function automatic int k_of(input int r);
    int k = 0;
    for (int j = 0; j < N; j++) if (j != r && snap_m[IW'(j)]) k++;
    return k;
  endfunction

  function automatic int lat(input int r);
`ifdef SYN_INT_SKIP_EN
    return k_of(r) + 2;
`else
    return N + 2;
`endif
  endfunction

  function automatic int exp_reads(input int r);
`ifdef SYN_INT_SKIP_EN
    return k_of(r);
`else
    return N - 1;
`endif
  endfunction

  function automatic logic [15:0] expected(input int r);
    longint s = 0;
    for (int j = 0; j < N; j++)
      if (j != r && snap_m[IW'(j)]) s += longint'(w_mem[IW'(r)][IW'(j)]);
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return 16'(s);
  endfunction

  // Consumer: stall a chosen row's EMIT for stall_n cycles, otherwise always ready.
  always @(posedge clk) begin
    #1;
    bus.cur_ready = !(active && row_m == stall_r && cyc >= due && cyc < due + stall_n);
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (reset_n) begin
      exp_valid = active && cyc >= due;
      chk("cur_valid", 32'(bus.cur_valid), 32'(exp_valid));
      chk("busy", 32'(busy), 32'(active && cyc > t0));
      chk("done", 32'(done), 32'(cyc == done_due));
      if (bus.w_rd_en) begin
        chk("rd_diag", 32'(bus.w_rd_row == bus.w_rd_col), 32'd0);
        chk("rd_row", 32'(bus.w_rd_row), 32'(row_m));
        chk("rd_ascend", 32'(int'(bus.w_rd_col) > last_col), 32'd1);
        last_col = int'(bus.w_rd_col);
        reads++;
      end
      if (exp_valid) begin
        if (cyc == due) emit_first[row_m] = cyc;
        chk("cur_idx", 32'(bus.cur_idx), 32'(row_m));
        chk("cur_data", 32'($unsigned(bus.cur_data)), 32'(expected(row_m)));
        chk("no_read_in_emit", 32'(bus.w_rd_en), 32'd0);
        if (bus.cur_ready) begin
          got[row_m]        = bus.cur_data;
          accept_cyc[row_m] = cyc;
          chk("reads_per_row", 32'(reads), 32'(exp_reads(row_m)));
          if (row_m == N - 1) begin
            active   = 1'b0;
            done_due = cyc + 1;
          end else begin
            row_m    = row_m + 1;
            due      = cyc + lat(row_m);
            last_col = -1;
            reads    = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) w_mem[i][j] = v;
  endtask

  task automatic start_pass(input logic [N-1:0] sp);
    spikes = sp;
    start  = 1'b1;
    snap_m = sp;
    t0     = cyc;
    row_m  = 0;
    due    = cyc + lat(0);
    last_col = -1;
    reads  = 0;
    for (int r = 0; r < N; r++) begin
      emit_first[r] = -1;
      accept_cyc[r] = -1;
    end
    active = 1'b1;
    tick();
    start  = 1'b0;
    spikes = ~sp;
  endtask

  // Returns positioned in the done cycle of the current pass.
  task automatic wait_done();
    int n = 0;
    while (!(!active && cyc == done_due) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"},  32'(bus.w_rd_en),   32'd0);
    chk({tag, "_rd_row"}, 32'(bus.w_rd_row),  32'd0);
    chk({tag, "_rd_col"}, 32'(bus.w_rd_col),  32'd0);
    chk({tag, "_valid"},  32'(bus.cur_valid), 32'd0);
    chk({tag, "_idx"},    32'(bus.cur_idx),   32'd0);
    chk({tag, "_data"},   32'($unsigned(bus.cur_data)), 32'd0);
    chk({tag, "_busy"},   32'(busy),          32'd0);
    chk({tag, "_done"},   32'(done),          32'd0);
  endtask

  initial begin
    int n;
    fill(16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Uniform 1.0 weights, all spiking: six terms per row
    fill(16'h0100);
    start_pass(7'h7F);
    wait_done();
    for (int r = 0; r < N; r++) chk("basic_data", 32'(got[r]), 32'h0600);
`ifndef SYN_INT_SKIP_EN
    for (int r = 0; r < N; r++) chk("basic_emit_cycle", 32'(emit_first[r] - t0), 32'(9 * r + 9));
    chk("basic_done_cycle", 32'(done_due - t0), 32'd64);
`endif

    // Positive saturation, started in the done cycle of the previous pass
    fill(16'h7000);
    start_pass(7'h7F);
    wait_done();
    for (int r = 0; r < N; r++) chk("sat_pos", 32'(got[r]), 32'h7FFF);

    fill(16'h9000);
    start_pass(7'h7F);
    wait_done();
    for (int r = 0; r < N; r++) chk("sat_neg", 32'(got[r]), 32'h8000);

    // Mixed signs; start pulse mid-pass with different spikes must be ignored
    fill(16'h0000);
    w_mem[0][0] = 16'sh1234;
    w_mem[0][1] = 16'sh0200;
    w_mem[0][2] = 16'shFF00;
    w_mem[3][0] = 16'sh7FFF;
    w_mem[3][1] = 16'sh0010;
    w_mem[3][2] = 16'sh0020;
    start_pass(7'h06);
    repeat (10) tick();
    spikes = 7'h7F;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_done();
    chk("mixed_row0", 32'(got[0]), 32'h0100);
    chk("mixed_row3", 32'(got[3]), 32'h0030);
    chk("mixed_row4", 32'(got[4]), 32'h0000);

    // Backpressure on row 2 for five cycles
    fill(16'h0100);
    stall_r = 2;
    stall_n = 5;
    start_pass(7'h7F);
    wait_done();
    stall_r = -1;
    stall_n = 0;
    chk("bp_data", 32'(got[2]), 32'h0600);
    chk("bp_hold_cycles", 32'(accept_cyc[2] - emit_first[2]), 32'd5);
`ifndef SYN_INT_SKIP_EN
    chk("bp_emit2", 32'(emit_first[2] - t0), 32'd27);
    chk("bp_done_cycle", 32'(done_due - t0), 32'd69);
`endif

    // Sparse input: only neuron 0 spikes
    fill(16'h0000);
    for (int i = 0; i < N; i++) w_mem[i][0] = 16'(i * 16);
    start_pass(7'h01);
    wait_done();
    for (int r = 0; r < N; r++) chk("sparse_data", 32'(got[r]), 32'(r * 16));
`ifdef SYN_INT_SKIP_EN
    chk("sparse_done_cycle", 32'(done_due - t0), 32'd21);
`else
    chk("sparse_done_cycle", 32'(done_due - t0), 32'd64);
`endif
    tick();

    // Asynchronous reset mid-READ of row 3
    fill(16'h0100);
    start_pass(7'h7F);
    n = 0;
    while (!(row_m == 3 && accept_cyc[2] >= 0 && cyc == accept_cyc[2] + 3) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("reset_wait_timeout", 32'd1, 32'd0);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset_n  = 1'b0;
    active   = 1'b0;
    done_due = -1;
    #1;
    chk_all_zero("midreset");
    tick();
    chk_all_zero("midreset_hold");
    reset_n = 1'b1;
    repeat (3) tick();

    // Fresh pass after reset: w[i][j] = i*0x40 - j*0x30
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) w_mem[i][j] = 16'(i * 64 - j * 48);
    start_pass(7'h5B);
    wait_done();
    chk("post_reset_row0", 32'(got[0]), 32'hFD60);
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
